// File: rtl/wrr_arbiter_if.sv
// wrr_arbiter_if: FIFO status, pop strobes and mux select between the arbiter and its neighbours
interface wrr_arbiter_if;
   logic       enb;
   logic       stall;
   logic       empty_vchanel0;
   logic       empty_vchanel1;
   logic       empty_vchanel2;
   logic       empty_vchanel3;
   logic [1:0] arbiter;
   logic       pop_vchanel0;
   logic       pop_vchanel1;
   logic       pop_vchanel2;
   logic       pop_vchanel3;
   logic       valid_out;
   modport master (
      output enb, stall, empty_vchanel0, empty_vchanel1, empty_vchanel2, empty_vchanel3,
      input  arbiter, pop_vchanel0, pop_vchanel1, pop_vchanel2, pop_vchanel3, valid_out
   );
   modport slave (
      input  enb, stall, empty_vchanel0, empty_vchanel1, empty_vchanel2, empty_vchanel3,
      output arbiter, pop_vchanel0, pop_vchanel1, pop_vchanel2, pop_vchanel3, valid_out
   );
endinterface

// File: rtl/wrr_arbiter.sv
// wrr_arbiter: weighted round-robin selection of four virtual-channel FIFOs with registered pops
module wrr_arbiter #(
   parameter int WEIGHT0 = 4,
   parameter int WEIGHT1 = 3,
   parameter int WEIGHT2 = 2,
   parameter int WEIGHT3 = 1
) (
   input logic         clk,
   input logic         rst,
   wrr_arbiter_if.slave bus
);
   localparam logic [3:0] W0M = (WEIGHT0 == 0) ? 4'd0 : 4'(WEIGHT0 - 1);
   localparam logic [3:0] W1M = (WEIGHT1 == 0) ? 4'd0 : 4'(WEIGHT1 - 1);
   localparam logic [3:0] W2M = (WEIGHT2 == 0) ? 4'd0 : 4'(WEIGHT2 - 1);
   localparam logic [3:0] W3M = (WEIGHT3 == 0) ? 4'd0 : 4'(WEIGHT3 - 1);
   logic [3:0] empty;
   logic [1:0] cur;
   logic [3:0] credit;
   logic [1:0] nxt;
   logic [1:0] gnt;
   logic [1:0] arb;
   logic [3:0] pop;
   logic [3:0] reload;
   logic       found;
   logic       keep;
   logic       valid;
   assign empty = {bus.empty_vchanel3, bus.empty_vchanel2, bus.empty_vchanel1, bus.empty_vchanel0};
   assign keep = !empty[cur] && credit != 4'd0;
   assign gnt = keep ? cur : nxt;
   assign reload = nxt == 2'd0 ? W0M : nxt == 2'd1 ? W1M : nxt == 2'd2 ? W2M : W3M;
   assign bus.arbiter = arb;
   assign bus.valid_out = valid;
   assign bus.pop_vchanel0 = pop[0];
   assign bus.pop_vchanel1 = pop[1];
   assign bus.pop_vchanel2 = pop[2];
   assign bus.pop_vchanel3 = pop[3];
   // first non-empty channel after cur, wrapping back to cur itself last
   always_comb begin
      found = 1'b0;
      nxt = cur;
      for (int k = 4; k >= 1; k--)
         if (!empty[cur + 2'(k)]) begin
            found = 1'b1;
            nxt = cur + 2'(k);
         end
   end
   // grant and turn bookkeeping; an idle cycle leaves the turn intact so it can resume
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         cur <= 2'd3;
         credit <= 4'd0;
         arb <= 2'd0;
         pop <= 4'd0;
         valid <= 1'b0;
      end else if (!bus.enb || bus.stall || !found) begin
         pop <= 4'd0;
         valid <= 1'b0;
      end else begin
         cur <= gnt;
         credit <= keep ? credit - 4'd1 : reload;
         arb <= gnt;
         pop <= 4'b0001 << gnt;
         valid <= 1'b1;
      end
endmodule

// File: tb/tb_wrr_arbiter.sv
// tb_wrr_arbiter: randomized and directed checks of wrr_arbiter against a turn-based reference model
module tb_wrr_arbiter;
   logic clk = 1'b0;
   logic rst = 1'b0;
   int total = 0;
   int bad = 0;
   int w [4] = '{4, 3, 2, 1};
   int m_owner;
   int m_left;
   logic [1:0] exp_arb;
   logic [3:0] exp_pop;
   logic       exp_val;
   wrr_arbiter_if bus ();
   wrr_arbiter dut (.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;

   function automatic logic [6:0] got();
      return {bus.arbiter, bus.pop_vchanel3, bus.pop_vchanel2, bus.pop_vchanel1, bus.pop_vchanel0, bus.valid_out};
   endfunction

   function automatic logic [6:0] want();
      return {exp_arb, exp_pop, exp_val};
   endfunction

   function automatic void model_reset();
      m_owner = 3;
      m_left = 0;
      exp_arb = 2'd0;
      exp_pop = 4'd0;
      exp_val = 1'b0;
   endfunction

   function automatic void model_edge(input logic [3:0] e, input logic en, input logic st);
      int g;
      g = -1;
      exp_pop = 4'd0;
      exp_val = 1'b0;
      if (!en || st) return;
      if (!e[m_owner] && m_left > 0) begin
         g = m_owner;
         m_left = m_left - 1;
      end else
         for (int k = 1; k <= 4 && g < 0; k++)
            if (!e[(m_owner + k) % 4]) begin
               g = (m_owner + k) % 4;
               m_owner = g;
               m_left = (w[g] < 1 ? 1 : w[g]) - 1;
            end
      if (g >= 0) begin
         exp_arb = 2'(g);
         exp_pop[g] = 1'b1;
         exp_val = 1'b1;
      end
   endfunction

   task automatic drive(input logic [3:0] e, input logic en, input logic st);
      bus.empty_vchanel0 = e[0];
      bus.empty_vchanel1 = e[1];
      bus.empty_vchanel2 = e[2];
      bus.empty_vchanel3 = e[3];
      bus.enb = en;
      bus.stall = st;
   endtask

   task automatic step(input logic [3:0] e, input logic en, input logic st);
      drive(e, en, st);
      @(posedge clk);
      model_edge(e, en, st);
      #1;
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      model_reset();
   endtask

   task automatic test_reset();
      drive(4'hF, 1'b1, 1'b0);
      rst = 1'b0;
      model_reset();
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         total++;
         if (got() !== 7'd0) begin
            bad++;
            $display("FAIL reset_hold got=%b want=%b", got(), 7'd0);
         end
      end
      @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step(4'hF, 1'b1, 1'b0);
         total++;
         if (got() !== 7'd0 || want() !== 7'd0) begin
            bad++;
            $display("FAIL reset_idle got=%b want=%b", got(), 7'd0);
         end
      end
   endtask

   task automatic test_round_robin();
      int seq [10] = '{0, 0, 0, 0, 1, 1, 1, 2, 2, 3};
      apply_reset();
      for (int i = 0; i < 30; i++) begin
         step(4'h0, 1'b1, 1'b0);
         total++;
         if (got() !== want() || bus.arbiter !== 2'(seq[i % 10]) || !bus.valid_out) begin
            bad++;
            $display("FAIL round_robin i=%0d got=%b want=%b seq=%0d", i, got(), want(), seq[i % 10]);
         end
      end
   endtask

   task automatic test_single_channel();
      apply_reset();
      for (int i = 0; i < 8; i++) begin
         step(4'b1011, 1'b1, 1'b0);
         total++;
         if (got() !== want() || got() !== {2'd2, 4'b0100, 1'b1}) begin
            bad++;
            $display("FAIL single_ch2 i=%0d got=%b want=%b", i, got(), {2'd2, 4'b0100, 1'b1});
         end
      end
   endtask

   task automatic test_skip();
      int seq [5] = '{0, 0, 0, 0, 3};
      apply_reset();
      for (int i = 0; i < 15; i++) begin
         step(4'b0110, 1'b1, 1'b0);
         total++;
         if (got() !== want() || bus.arbiter !== 2'(seq[i % 5])) begin
            bad++;
            $display("FAIL skip_ch12 i=%0d got=%b want=%b seq=%0d", i, got(), want(), seq[i % 5]);
         end
      end
   endtask

   task automatic test_stall();
      int seq [10] = '{0, 0, -1, -1, -1, 0, 0, 1, 1, 1};
      apply_reset();
      for (int i = 0; i < 10; i++) begin
         step(4'h0, 1'b1, seq[i] < 0);
         total++;
         if (got() !== want() || (seq[i] < 0 ? got() !== 7'd0 : bus.arbiter !== 2'(seq[i]) || !bus.valid_out)) begin
            bad++;
            $display("FAIL stall i=%0d got=%b want=%b", i, got(), want());
         end
      end
   endtask

   task automatic test_one_pop();
      apply_reset();
      step(4'hF, 1'b1, 1'b0);
      step(4'b1101, 1'b1, 1'b0);
      total++;
      if (got() !== want() || got() !== {2'd1, 4'b0010, 1'b1}) begin
         bad++;
         $display("FAIL one_pop_grant got=%b want=%b", got(), {2'd1, 4'b0010, 1'b1});
      end
      step(4'hF, 1'b1, 1'b0);
      total++;
      if (got() !== want() || got() !== {2'd1, 4'b0000, 1'b0}) begin
         bad++;
         $display("FAIL one_pop_after got=%b want=%b", got(), {2'd1, 4'b0000, 1'b0});
      end
   endtask

   task automatic test_reset_mid_turn();
      apply_reset();
      for (int i = 0; i < 5; i++) step(4'h0, 1'b1, 1'b0);
      #2;
      rst = 1'b0;
      #1;
      total++;
      if (got() !== 7'd0) begin
         bad++;
         $display("FAIL async_reset got=%b want=%b", got(), 7'd0);
      end
      #2;
      rst = 1'b1;
      model_reset();
      for (int i = 0; i < 5; i++) begin
         step(4'h0, 1'b1, 1'b0);
         total++;
         if (got() !== want() || bus.arbiter !== (i < 4 ? 2'd0 : 2'd1)) begin
            bad++;
            $display("FAIL reset_restart i=%0d got=%b want=%b", i, got(), want());
         end
      end
   endtask

   task automatic test_random();
      apply_reset();
      for (int i = 0; i < 400; i++) begin
         step(4'($urandom), ($urandom % 8) != 0, ($urandom % 6) == 0);
         total++;
         if (got() !== want()) begin
            bad++;
            $display("FAIL random i=%0d got=%b want=%b", i, got(), want());
         end
      end
   endtask

   initial begin
      drive(4'hF, 1'b0, 1'b0);
      test_reset();
      test_round_robin();
      test_single_channel();
      test_skip();
      test_stall();
      test_one_pop();
      test_reset_mid_turn();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
